if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage with its IF/ID pipeline register. It sits directly upstream of the ID stage and its hazard-detection unit. It drives a variable-latency instruction memory through a req/ready handshake and honours the hazard unit's freeze and the ID stage's branch redirect. It presents one instruction, or a bubble, to ID every cycle.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INSTR, 32'h0000_0000, instruction word driven to ID on a bubble

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hazard detected; hold IF/ID contents and stop fetch progress
- branch_taken  in  1  ID-stage branch resolved taken; ignored while freeze=1
- branch_addr  in  32  branch target; valid when branch_taken=1
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  memory returns imem_rdata this cycle; meaningful only with imem_req=1
- imem_rdata  in  32  fetched instruction word
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  address of the IF/ID instruction + 4
- if_id_instr  out  32  IF/ID instruction; NOP_INSTR when if_id_valid=0

## Operation
- Internal registers:
  - imem_addr: address of the current request.
  - redirect_addr: pending branch target.
  - hold buffer: hold_instr, hold_pc.
  - state: FETCH, HOLD or DISCARD.
- Definitions: B = branch_taken & ~freeze; R = imem_req & imem_ready.
- imem_req = 1 in FETCH and DISCARD, and 0 in HOLD.
- FETCH:
  - B & R: drop rdata; imem_addr <= branch_addr; IF/ID <= bubble; stay in FETCH.
  - B & ~R: redirect_addr <= branch_addr; IF/ID <= bubble; go to DISCARD.
  - freeze & R: hold_instr <= rdata; hold_pc <= imem_addr+4; imem_addr <= imem_addr+4; IF/ID unchanged; go to HOLD.
  - freeze & ~R: IF/ID unchanged.
  - no freeze, no B, R: IF/ID <= {valid=1, imem_addr+4, rdata}; imem_addr <= imem_addr+4.
  - no freeze, no B, ~R: IF/ID <= bubble.
- HOLD:
  - B: discard hold; imem_addr <= branch_addr; IF/ID <= bubble; go to FETCH.
  - freeze: all state unchanged.
  - otherwise: IF/ID <= {1, hold_pc, hold_instr}; go to FETCH.
- DISCARD:
  - Waits for the abandoned request. imem_addr is held and the returned word is never used.
  - B: redirect_addr <= branch_addr; the latest target wins.
  - R: imem_addr <= redirect_addr; go to FETCH.
  - IF/ID <= bubble every DISCARD cycle unless freeze=1, in which case IF/ID is unchanged.
- Bubble means if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
- Address arithmetic is 32-bit unsigned; +4 wraps 32'hFFFF_FFFC → 0. No alignment check; the low two bits pass through.

## Timing
- Reset (rst=0, asynchronous):
  - state=FETCH, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
  - Hold buffer is empty; imem_req is 0 while rst=0.
- The first request (addr RESET_PC) is driven in the first cycle after reset deassertion.
- Reset mid-request abandons the outstanding request. The memory must accept imem_req dropping without ready.
- Latency: with a zero-wait memory (imem_ready=1 whenever requested), a word fetched in cycle n appears on IF/ID in cycle n+1. Throughput is one instruction per cycle.
- Each extra memory wait cycle inserts one bubble into IF/ID.
- A taken branch in cycle n:
  - IF/ID shows a bubble in n+1.
  - The target is fetched starting in n+1 if the old request completed in n. Otherwise it is fetched starting the cycle after the old request completes.
- freeze has priority over branch_taken. Handshake data is never lost during freeze: the hold buffer captures it.

## Test plan
- Reset release, zero-wait memory returning word = address: IF/ID shows (pc 4, instr 0), (8, 4), (12, 8) on consecutive cycles; imem_req=0 during reset.
- imem_ready low for 2 cycles on the 0x8 fetch → two bubbles, then (pc 0xC, instr 0x8); imem_addr stays 0x8 throughout the wait.
- freeze=1 for 3 cycles while 0x10 is returned → IF/ID holds its prior value; state enters HOLD with imem_req=0; on release IF/ID shows (0x14, word@0x10), then 0x14 is fetched.
- branch_taken=1 to 0x100 while the 0x20 fetch is pending; ready arrives 2 cycles later → word@0x20 is dropped; imem_addr moves to 0x100 on the completion edge; the next valid IF/ID entry is (0x104, word@0x100).
- freeze=1 and branch_taken=1 together → branch ignored, IF/ID held; branch_taken=1 again after freeze drops → redirect to branch_addr.
- imem_addr=32'hFFFF_FFFC fetched → if_id_pc=0 and the next request address is 0; assert rst low mid-request → all outputs at reset values immediately, first request is again RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Talks to a variable-latency instruction memory over req/ready and honours freeze and branch redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] redirect_addr;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        take_branch;
  logic        handshake;
  logic [31:0] next_addr;

  // Request is gated by reset so the memory sees it drop immediately on rst=0.
  assign imem_req    = rst && (state != HOLD);
  assign take_branch = branch_taken && !freeze;
  assign handshake   = imem_req && imem_ready;
  assign next_addr   = imem_addr + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FETCH;
      imem_addr     <= RESET_PC;
      redirect_addr <= RESET_PC;
      hold_instr    <= NOP_INSTR;
      hold_pc       <= 32'h0;
      if_id_valid   <= 1'b0;
      if_id_pc      <= 32'h0;
      if_id_instr   <= NOP_INSTR;
    end else begin
      case (state)
        FETCH: begin
          if (take_branch) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
            if (handshake) begin
              imem_addr <= branch_addr;
            end else begin
              redirect_addr <= branch_addr;
              state         <= DISCARD;
            end
          end else if (freeze) begin
            // Park the returned word so nothing is lost while ID is stalled.
            if (handshake) begin
              hold_instr <= imem_rdata;
              hold_pc    <= next_addr;
              imem_addr  <= next_addr;
              state      <= HOLD;
            end
          end else if (handshake) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= next_addr;
            if_id_instr <= imem_rdata;
            imem_addr   <= next_addr;
          end else begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
          end
        end

        HOLD: begin
          if (take_branch) begin
            imem_addr   <= branch_addr;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
            state       <= FETCH;
          end else if (!freeze) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= hold_pc;
            if_id_instr <= hold_instr;
            state       <= FETCH;
          end
        end

        DISCARD: begin
          if (!freeze) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
          end
          // A branch arriving on the completion cycle is the newest target.
          if (handshake) begin
            imem_addr <= take_branch ? branch_addr : redirect_addr;
            state     <= FETCH;
          end else if (take_branch) begin
            redirect_addr <= branch_addr;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, reset corner cases,
// then random stimulus against a queue-based reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns word == address.
  assign imem_rdata = imem_addr;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic f, input logic b, input logic [31:0] ba, input logic r,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] i);
    vec_t t;
    t.frz = f; t.br = b; t.baddr = ba; t.rdy = r;
    t.req = q; t.addr = a; t.valid = v; t.pc = p; t.instr = i;
    return t;
  endfunction

  task automatic chk(input string name, input logic q, input logic [31:0] a,
                     input logic v, input logic [31:0] p, input logic [31:0] i);
    checks++;
    if (imem_req !== q || imem_addr !== a || if_id_valid !== v || if_id_pc !== p || if_id_instr !== i) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, expected req=%0b addr=%h valid=%0b pc=%h instr=%h",
               name, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, q, a, v, p, i);
    end else begin
      $display("ok   %s: req=%0b addr=%h valid=%0b pc=%h instr=%h",
               name, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic drive(input logic f, input logic b, input logic [31:0] ba, input logic r);
    freeze = f; branch_taken = b; branch_addr = ba; imem_ready = r;
  endtask

  // Reference model: one outstanding fetch address, an optional parked word,
  // and an optional pending redirect target.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } slot_t;
  slot_t       m_parked[$];
  logic [31:0] m_addr;
  bit          m_pending;
  logic [31:0] m_target;
  logic        e_valid;
  logic [31:0] e_pc, e_instr;

  function automatic logic m_req();
    return m_parked.size() == 0;
  endfunction

  task automatic model_reset();
    m_parked.delete();
    m_addr = RESET_PC; m_pending = 0; m_target = 32'h0;
    e_valid = 1'b0; e_pc = 32'h0; e_instr = NOP_INSTR;
  endtask

  task automatic model_bubble();
    e_valid = 1'b0; e_pc = 32'h0; e_instr = NOP_INSTR;
  endtask

  task automatic model_step(input logic f, input logic b, input logic [31:0] ba, input logic r);
    bit          go_branch;
    bit          done;
    slot_t       s;
    logic [31:0] word;
    go_branch = b && !f;
    done      = m_req() && r;
    word      = m_addr;
    if (m_parked.size() != 0) begin
      if (go_branch) begin
        m_parked.delete(); m_addr = ba; model_bubble();
      end else if (!f) begin
        s = m_parked.pop_front();
        e_valid = 1'b1; e_pc = s.pc; e_instr = s.instr;
      end
    end else if (m_pending) begin
      if (!f) model_bubble();
      if (go_branch) m_target = ba;
      if (done) begin m_addr = m_target; m_pending = 0; end
    end else if (go_branch) begin
      model_bubble();
      if (done) m_addr = ba;
      else begin m_pending = 1; m_target = ba; end
    end else if (done) begin
      if (f) begin
        s.pc = m_addr + 32'd4; s.instr = word;
        m_parked.push_back(s);
      end else begin
        e_valid = 1'b1; e_pc = m_addr + 32'd4; e_instr = word;
      end
      m_addr = m_addr + 32'd4;
    end else if (!f) begin
      model_bubble();
    end
  endtask

  initial begin
    // ---- reset state, memory ready held high to show it is ignored ----
    drive(0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 0, RESET_PC, 0, 32'h0, NOP_INSTR);
    rst = 1'b1;
    #1 chk("reset_release", 1, RESET_PC, 0, 32'h0, NOP_INSTR);

    // ---- directed table: inputs for the cycle, outputs after the edge ----
    vecs.push_back(mk(0,0,0,1,            1,32'h4,  1,32'h4,  32'h0));
    vecs.push_back(mk(0,0,0,1,            1,32'h8,  1,32'h8,  32'h4));
    vecs.push_back(mk(0,0,0,0,            1,32'h8,  0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,0,            1,32'h8,  0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'hC,  1,32'hC,  32'h8));
    vecs.push_back(mk(0,0,0,1,            1,32'h10, 1,32'h10, 32'hC));
    vecs.push_back(mk(1,0,0,1,            0,32'h14, 1,32'h10, 32'hC));
    vecs.push_back(mk(1,0,0,1,            0,32'h14, 1,32'h10, 32'hC));
    vecs.push_back(mk(1,0,0,0,            0,32'h14, 1,32'h10, 32'hC));
    vecs.push_back(mk(0,0,0,1,            1,32'h14, 1,32'h14, 32'h10));
    vecs.push_back(mk(0,0,0,1,            1,32'h18, 1,32'h18, 32'h14));
    vecs.push_back(mk(0,0,0,1,            1,32'h1C, 1,32'h1C, 32'h18));
    vecs.push_back(mk(0,0,0,1,            1,32'h20, 1,32'h20, 32'h1C));
    vecs.push_back(mk(0,1,32'h100,0,      1,32'h20, 0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,0,            1,32'h20, 0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h100,0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h104,1,32'h104,32'h100));
    vecs.push_back(mk(1,1,32'h200,0,      1,32'h104,1,32'h104,32'h100));
    vecs.push_back(mk(0,1,32'h200,0,      1,32'h104,0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h200,0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h204,1,32'h204,32'h200));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,1,32'hFFFF_FFFC,0,32'h0,NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h0,  1,32'h0,  32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,1,            1,32'h4,  1,32'h4,  32'h0));
    vecs.push_back(mk(1,0,0,1,            0,32'h8,  1,32'h4,  32'h0));
    vecs.push_back(mk(0,1,32'h40,0,       1,32'h40, 0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h44, 1,32'h44, 32'h40));
    vecs.push_back(mk(0,1,32'h80,0,       1,32'h44, 0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,1,32'h90,0,       1,32'h44, 0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h90, 0,32'h0,  NOP_INSTR));
    vecs.push_back(mk(0,0,0,1,            1,32'h94, 1,32'h94, 32'h90));

    foreach (vecs[k]) begin
      drive(vecs[k].frz, vecs[k].br, vecs[k].baddr, vecs[k].rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].valid, vecs[k].pc, vecs[k].instr);
    end

    // ---- reset asserted mid-request ----
    drive(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk("mid_reset_async", 0, RESET_PC, 0, 32'h0, NOP_INSTR);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("mid_reset_release", 1, RESET_PC, 0, 32'h0, NOP_INSTR);
    drive(0, 0, 0, 1);
    @(posedge clk); #1;
    chk("mid_reset_first", 1, 32'h4, 1, 32'h4, 32'h0);

    // ---- random stimulus against the reference model ----
    rst = 1'b0;
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1 chk("rand_start", m_req(), m_addr, e_valid, e_pc, e_instr);
    for (int n = 0; n < 600; n++) begin
      logic        f, b, r;
      logic [31:0] ba;
      f  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 4) < 3);
      ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
      drive(f, b, ba, r);
      model_step(f, b, ba, r);
      @(posedge clk); #1;
      chk($sformatf("rand%0d", n), m_req(), m_addr, e_valid, e_pc, e_instr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
